// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - streams RGB565 frame-buffer pixels into an RGB888 VGA/DVI pixel pipeline
module vga_pixel_fetch #(
    parameter int          P_IMG_W  = 512,
    parameter int          P_IMG_H  = 400,
    parameter logic [23:0] P_BORDER = 24'h000000,
    parameter logic [23:0] P_UFLOW  = 24'hFF00FF
) (
    input  logic        s_clk_sys,
    input  logic        s_rst,
    input  logic        i_enable,
    input  logic        i_frame,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [15:0] i_x_pos,
    input  logic [15:0] i_y_pos,
    input  logic        i_rd_valid,
    input  logic [15:0] i_rd_data,
    output logic        o_rd_ready,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic [15:0] o_uflow_cnt,
    output logic [19:0] o_frame_pixels,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Window limits as signed 16-bit so negative coordinates fall outside.
    localparam logic signed [15:0] IMG_W_S = 16'(P_IMG_W);
    localparam logic signed [15:0] IMG_H_S = 16'(P_IMG_H);

    state_t      state;
    state_t      state_nxt;
    logic        in_win;
    logic        pop;
    logic        uflow_hit;
    logic [23:0] colour_nxt;
    logic [23:0] colour_q;
    logic [19:0] pix_cnt;
    logic [19:0] pix_inc;

    // State register; reset wins over any same-cycle enable/frame.
    always_ff @(posedge s_clk_sys) begin
        if (s_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: arm on enable, start streaming at a frame boundary, stop only at a frame boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_enable) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!i_enable)    state_nxt = ST_IDLE;
                else if (i_frame) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (i_frame && !i_enable) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Window decode and FIFO handshake for the current pixel.
    always_comb begin
        in_win = i_de
               && ($signed(i_x_pos) >= 16'sd0) && ($signed(i_y_pos) >= 16'sd0)
               && ($signed(i_x_pos) < IMG_W_S) && ($signed(i_y_pos) < IMG_H_S);
        o_rd_ready = in_win && (state == ST_STREAM);
        pop        = o_rd_ready && i_rd_valid;
        uflow_hit  = o_rd_ready && !i_rd_valid;
        pix_inc    = pix_cnt + {19'd0, pop};
    end

    // Colour select: expanded pixel, underflow marker, border, or black during blanking.
    always_comb begin
        colour_nxt = 24'h000000;
        if (i_de) begin
            if (pop) begin
                colour_nxt = {i_rd_data[15:11], i_rd_data[15:13],
                              i_rd_data[10:5],  i_rd_data[10:9],
                              i_rd_data[4:0],   i_rd_data[4:2]};
            end else if (uflow_hit) begin
                colour_nxt = P_UFLOW;
            end else begin
                colour_nxt = P_BORDER;
            end
        end
    end

    // One-cycle output stage keeping sync/de aligned with colour.
    always_ff @(posedge s_clk_sys) begin
        if (s_rst) begin
            o_hsync  <= 1'b0;
            o_vsync  <= 1'b0;
            o_de     <= 1'b0;
            colour_q <= 24'h000000;
        end else begin
            o_hsync  <= i_hsync;
            o_vsync  <= i_vsync;
            o_de     <= i_de;
            colour_q <= colour_nxt;
        end
    end

    // Saturating count of cycles where a pixel was wanted but the FIFO was empty.
    always_ff @(posedge s_clk_sys) begin
        if (s_rst) begin
            o_uflow_cnt <= 16'd0;
        end else if (uflow_hit && (o_uflow_cnt != 16'hFFFF)) begin
            o_uflow_cnt <= o_uflow_cnt + 16'd1;
        end
    end

    // Per-frame pop counter; a pop coincident with the frame pulse belongs to the closing frame.
    always_ff @(posedge s_clk_sys) begin
        if (s_rst) begin
            pix_cnt        <= 20'd0;
            o_frame_pixels <= 20'd0;
        end else if (i_frame) begin
            pix_cnt <= 20'd0;
            if (state == ST_STREAM) begin
                o_frame_pixels <= pix_inc;
            end
        end else begin
            pix_cnt <= pix_inc;
        end
    end

    assign o_red   = colour_q[23:16];
    assign o_green = colour_q[15:8];
    assign o_blue  = colour_q[7:0];
    assign o_state = state;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - directed self-checking bench for vga_pixel_fetch
module tb_vga_pixel_fetch;

    localparam int          W      = 16;
    localparam int          H      = 8;
    localparam int          FW     = 20;
    localparam int          FH     = 10;
    localparam logic [23:0] BORDER = 24'h123456;
    localparam logic [23:0] UFLOW  = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] x_pos;
    logic [15:0] y_pos;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [15:0] uflow_cnt;
    logic [19:0] frame_pixels;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;
    int errs;

    vga_pixel_fetch #(
        .P_IMG_W (W),
        .P_IMG_H (H),
        .P_BORDER(BORDER),
        .P_UFLOW (UFLOW)
    ) dut (
        .s_clk_sys     (clk),
        .s_rst         (rst),
        .i_enable      (enable),
        .i_frame       (frame),
        .i_hsync       (hsync),
        .i_vsync       (vsync),
        .i_de          (de),
        .i_x_pos       (x_pos),
        .i_y_pos       (y_pos),
        .i_rd_valid    (rd_valid),
        .i_rd_data     (rd_data),
        .o_rd_ready    (rd_ready),
        .o_hsync       (hsync_o),
        .o_vsync       (vsync_o),
        .o_de          (de_o),
        .o_red         (red),
        .o_green       (green),
        .o_blue        (blue),
        .o_uflow_cnt   (uflow_cnt),
        .o_frame_pixels(frame_pixels),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic d, input int x, input int y, input logic v, input logic [15:0] data);
        de       = d;
        x_pos    = 16'(x);
        y_pos    = 16'(y);
        rd_valid = v;
        rd_data  = data;
    endtask

    function automatic logic [23:0] expand(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    // Raster scan of lines y_lo..y_hi; counts ready/colour disagreements with the expected behaviour.
    task automatic scan(input int y_lo, input int y_hi, input logic streaming, input logic [15:0] data,
                        output int e);
        logic win;
        e = 0;
        for (int y = y_lo; y <= y_hi; y++) begin
            for (int x = 0; x < FW; x++) begin
                px(1'b1, x, y, 1'b1, data);
                #1;
                win = streaming && (x < W) && (y < H);
                if (rd_ready !== win) e++;
                tick();
                if ({red, green, blue} !== (win ? expand(data) : BORDER)) e++;
            end
        end
        px(1'b0, 0, 0, 1'b0, 16'h0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; frame = 1'b0; hsync = 1'b0; vsync = 1'b0;
        px(1'b0, 0, 0, 1'b0, 16'h0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        chk("rst_colour", 32'({red, green, blue}), 32'd0);
        chk("rst_uflow", 32'(uflow_cnt), 32'd0);
        chk("rst_frame_pixels", 32'(frame_pixels), 32'd0);

        // Enabled but no frame pulse: armed, never pops.
        enable = 1'b1;
        tick();
        chk("sync_state", 32'(state), 32'd1);
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            px(i[0], i % FW, 0, 1'b1, 16'hF800);
            #1;
            if (rd_ready !== 1'b0) errs++;
            tick();
            if ({red, green, blue} !== (i[0] ? BORDER : 24'h0)) errs++;
        end
        chk("sync_no_pop", 32'(errs), 32'd0);
        chk("sync_state_hold", 32'(state), 32'd1);

        // Frame pulse starts streaming.
        px(1'b0, 0, 0, 1'b0, 16'h0);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        chk("stream_state", 32'(state), 32'd2);

        px(1'b1, 0, 0, 1'b1, 16'hF800); hsync = 1'b1;
        #1;
        chk("ready_in_win", 32'(rd_ready), 32'd1);
        tick();
        chk("red_pixel", 32'({red, green, blue}), 32'hFF0000);
        chk("de_delay", 32'(de_o), 32'd1);
        chk("hsync_delay", 32'(hsync_o), 32'd1);
        hsync = 1'b0;
        px(1'b1, 0, 0, 1'b1, 16'h07E0);
        tick();
        chk("green_pixel", 32'({red, green, blue}), 32'h00FF00);
        px(1'b1, 1, 0, 1'b1, 16'h001F);
        tick();
        chk("blue_pixel", 32'({red, green, blue}), 32'h0000FF);
        px(1'b1, 2, 0, 1'b1, 16'hA5A5);
        tick();
        chk("mixed_pixel", 32'({red, green, blue}), 32'hA5B629);
        px(1'b1, W, 0, 1'b1, 16'hFFFF);
        #1;
        chk("ready_x_edge", 32'(rd_ready), 32'd0);
        tick();
        chk("border_x_edge", 32'({red, green, blue}), 32'(BORDER));
        px(1'b1, -1, 0, 1'b1, 16'hFFFF);
        #1;
        chk("ready_x_neg", 32'(rd_ready), 32'd0);
        tick();
        chk("border_x_neg", 32'({red, green, blue}), 32'(BORDER));
        px(1'b1, 0, H, 1'b1, 16'hFFFF);
        tick();
        chk("border_y_edge", 32'({red, green, blue}), 32'(BORDER));
        px(1'b0, 3, 0, 1'b1, 16'hFFFF); vsync = 1'b1;
        #1;
        chk("ready_no_de", 32'(rd_ready), 32'd0);
        tick();
        chk("blank_colour", 32'({red, green, blue}), 32'd0);
        chk("blank_de", 32'(de_o), 32'd0);
        chk("vsync_delay", 32'(vsync_o), 32'd1);
        vsync = 1'b0;

        // Ten underflow cycles.
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            px(1'b1, 3 + i, 1, 1'b0, 16'hF800);
            tick();
            if ({red, green, blue} !== UFLOW) errs++;
        end
        chk("uflow_colour", 32'(errs), 32'd0);
        chk("uflow_cnt10", 32'(uflow_cnt), 32'd10);

        // Frame close with a coincident pop: 4 earlier pops + this one.
        px(1'b1, 1, 1, 1'b1, 16'h0000);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        px(1'b0, 0, 0, 1'b0, 16'h0);
        chk("frame_pix_5", 32'(frame_pixels), 32'd5);

        // Full frame of red.
        scan(0, FH - 1, 1'b1, 16'hF800, errs);
        chk("full_frame_scan", 32'(errs), 32'd0);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        chk("frame_pix_full", 32'(frame_pixels), 32'(W * H));
        chk("uflow_unchanged", 32'(uflow_cnt), 32'd10);

        // Disable mid-frame: frame completes, then idle for the next frame.
        scan(0, 3, 1'b1, 16'h001F, errs);
        chk("half_frame_a", 32'(errs), 32'd0);
        enable = 1'b0;
        scan(4, FH - 1, 1'b1, 16'h07E0, errs);
        chk("half_frame_b", 32'(errs), 32'd0);
        chk("stream_after_disable", 32'(state), 32'd2);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        chk("disable_frame_pix", 32'(frame_pixels), 32'(W * H));
        chk("idle_after_frame", 32'(state), 32'd0);
        scan(0, FH - 1, 1'b0, 16'hF800, errs);
        chk("idle_frame_scan", 32'(errs), 32'd0);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        chk("idle_frame_pix_kept", 32'(frame_pixels), 32'(W * H));

        // Underflow counter saturation.
        enable = 1'b1;
        tick();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        chk("restream_state", 32'(state), 32'd2);
        px(1'b1, 5, 5, 1'b0, 16'h0);
        for (int i = 0; i < 65530; i++) tick();
        chk("uflow_saturate", 32'(uflow_cnt), 32'hFFFF);

        // Reset mid-stream on a pop cycle, with enable and frame also asserted.
        px(1'b1, 4, 4, 1'b1, 16'hFFFF);
        frame = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        frame = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_ready", 32'(rd_ready), 32'd0);
        chk("mid_rst_colour", 32'({red, green, blue}), 32'd0);
        chk("mid_rst_de", 32'(de_o), 32'd0);
        chk("mid_rst_uflow", 32'(uflow_cnt), 32'd0);
        chk("mid_rst_frame_pix", 32'(frame_pixels), 32'd0);

        // Counter restarts from zero after reset.
        px(1'b0, 0, 0, 1'b0, 16'h0);
        tick();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        for (int i = 0; i < 3; i++) begin
            px(1'b1, i, 0, 1'b1, 16'h1234);
            tick();
        end
        px(1'b0, 0, 0, 1'b0, 16'h0);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        chk("post_rst_count", 32'(frame_pixels), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
